sgd_x_rmw_engine: RTL

Parametrised read-modify-write engine for the distributed-SGD model memory (x_updated banks). Each accepted beat of accumulated-gradient lanes reads one model row and writes back the combined value. Combining is selectable per beat: subtract, add, overwrite or clear. The engine forwards in-flight results so that short dimensions, where a row is revisited before its write lands, stay correct, and it can saturate results instead of wrapping. It sits between the gradient accumulator and the dual-port model BRAM (read-first, RD_LAT-cycle read latency).

---
 rtl/sgd_x_rmw_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sgd_x_rmw_engine.sv
// Read-modify-write engine for x_updated model rows: subtract/add/overwrite/clear
// per beat, with forwarding of results the read-first BRAM cannot yet return.
module sgd_x_rmw_engine #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned SATURATE  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_started,
  input  logic [ADDR_W:0]             i_row_count,
  input  logic [1:0]                  i_mode,
  input  logic                        i_grad_valid,
  input  logic [NUM_LANES*DATA_W-1:0] i_grad_data,
  output logic [ADDR_W-1:0]           o_rd_addr,
  input  logic [NUM_LANES*DATA_W-1:0] i_rd_data,
  output logic                        o_wr_en,
  output logic [ADDR_W-1:0]           o_wr_addr,
  output logic [NUM_LANES*DATA_W-1:0] o_wr_data,
  output logic                        o_pass_done,
  output logic                        o_sat_flag
);
  localparam int unsigned ROW_W = NUM_LANES * DATA_W;
  // A write lands RD_LAT+2 cycles after acceptance and a read-first read in that
  // same cycle still misses it, so results are kept for RD_LAT+2 cycles.
  localparam int unsigned HIST  = RD_LAT + 2;
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [1:0] M_SUB = 2'd0;
  localparam logic [1:0] M_ADD = 2'd1;
  localparam logic [1:0] M_SET = 2'd2;

  logic              r_started_q;
  logic [ADDR_W:0]   r_row_count;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_sat;

  logic              r_p_vld  [1:RD_LAT];
  logic              r_p_last [1:RD_LAT];
  logic [ADDR_W-1:0] r_p_addr [1:RD_LAT];
  logic [1:0]        r_p_mode [1:RD_LAT];
  logic [ROW_W-1:0]  r_p_grad [1:RD_LAT];

  logic              r_h_vld  [1:HIST];
  logic              r_h_last [1:HIST];
  logic [ADDR_W-1:0] r_h_addr [1:HIST];
  logic [ROW_W-1:0]  r_h_data [1:HIST];

  logic              w_rise;
  logic              w_accept;
  logic              w_is_last;
  logic [ADDR_W:0]   w_rc;
  logic [ADDR_W:0]   w_rc_m1;
  logic [ROW_W-1:0]  w_x;
  logic [ROW_W-1:0]  w_res;
  logic              w_clamp;
  logic [DATA_W-1:0] w_xl;
  logic [DATA_W-1:0] w_gl;
  logic [DATA_W:0]   w_sum;

  assign w_rise    = i_started & ~r_started_q;
  assign w_accept  = i_started & i_grad_valid;
  assign w_rc      = w_rise ? i_row_count : r_row_count;
  assign w_rc_m1   = (w_rc == '0) ? '0 : w_rc - (ADDR_W+1)'(1);
  assign w_is_last = ({1'b0, r_rd_addr} == w_rc_m1);

  // Operand select: oldest-to-youngest scan so the youngest matching result wins.
  always_comb begin
    w_x = i_rd_data;
    for (int k = HIST; k >= 1; k--) begin
      if (r_h_vld[k] && (r_h_addr[k] == r_p_addr[RD_LAT])) w_x = r_h_data[k];
    end
  end

  always_comb begin
    w_res   = '0;
    w_clamp = 1'b0;
    w_xl    = '0;
    w_gl    = '0;
    w_sum   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_xl = w_x[l*DATA_W +: DATA_W];
      w_gl = r_p_grad[RD_LAT][l*DATA_W +: DATA_W];
      if (r_p_mode[RD_LAT] == M_SUB) w_sum = {w_xl[DATA_W-1], w_xl} - {w_gl[DATA_W-1], w_gl};
      else                           w_sum = {w_xl[DATA_W-1], w_xl} + {w_gl[DATA_W-1], w_gl};
      case (r_p_mode[RD_LAT])
        M_SUB, M_ADD: begin
          if ((SATURATE != 0) && (w_sum[DATA_W] != w_sum[DATA_W-1])) begin
            w_res[l*DATA_W +: DATA_W] = w_sum[DATA_W] ? S_MIN : S_MAX;
            w_clamp = 1'b1;
          end else begin
            w_res[l*DATA_W +: DATA_W] = w_sum[DATA_W-1:0];
          end
        end
        M_SET:   w_res[l*DATA_W +: DATA_W] = w_gl;
        default: w_res[l*DATA_W +: DATA_W] = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_started_q <= 1'b0;
      r_row_count <= '0;
      r_rd_addr   <= '0;
      r_sat       <= 1'b0;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_p_vld[k]  <= 1'b0;
        r_p_last[k] <= 1'b0;
        r_p_addr[k] <= '0;
        r_p_mode[k] <= '0;
        r_p_grad[k] <= '0;
      end
      for (int k = 1; k <= HIST; k++) begin
        r_h_vld[k]  <= 1'b0;
        r_h_last[k] <= 1'b0;
        r_h_addr[k] <= '0;
        r_h_data[k] <= '0;
      end
    end else begin
      r_started_q <= i_started;
      if (w_rise) r_row_count <= i_row_count;
      if (!i_started)    r_rd_addr <= '0;
      else if (w_accept) r_rd_addr <= w_is_last ? '0 : r_rd_addr + ADDR_W'(1);
      if (r_p_vld[RD_LAT] && w_clamp) r_sat <= 1'b1;
      else if (w_rise)                r_sat <= 1'b0;

      r_p_vld[1]  <= w_accept;
      r_p_last[1] <= w_is_last;
      r_p_addr[1] <= r_rd_addr;
      r_p_mode[1] <= i_mode;
      r_p_grad[1] <= i_grad_data;
      for (int k = 2; k <= RD_LAT; k++) begin
        r_p_vld[k]  <= r_p_vld[k-1];
        r_p_last[k] <= r_p_last[k-1];
        r_p_addr[k] <= r_p_addr[k-1];
        r_p_mode[k] <= r_p_mode[k-1];
        r_p_grad[k] <= r_p_grad[k-1];
      end

      r_h_vld[1]  <= r_p_vld[RD_LAT];
      r_h_last[1] <= r_p_last[RD_LAT];
      r_h_addr[1] <= r_p_addr[RD_LAT];
      r_h_data[1] <= w_res;
      for (int k = 2; k <= HIST; k++) begin
        r_h_vld[k]  <= r_h_vld[k-1];
        r_h_last[k] <= r_h_last[k-1];
        r_h_addr[k] <= r_h_addr[k-1];
        r_h_data[k] <= r_h_data[k-1];
      end
    end
  end

  // Output stage is the second history slot.
  assign o_rd_addr   = r_rd_addr;
  assign o_wr_en     = r_h_vld[2];
  assign o_wr_addr   = r_h_addr[2];
  assign o_wr_data   = r_h_data[2];
  assign o_pass_done = r_h_vld[2] & r_h_last[2];
  assign o_sat_flag  = r_sat;

endmodule
